// File: rtl/lrf_pkg.sv
// Shared encodings and sizing helpers for the LRF frame sequencer.
package lrf_pkg;

    typedef enum logic [1:0] {
        ST_PRIME = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2
    } lrf_state_e;

    typedef enum logic [1:0] {
        AVG_INIT    = 2'd0,
        AVG_SUB_REF = 2'd1,
        AVG_SUB_OLD = 2'd2
    } lrf_avg_mode_e;

    function automatic int beats_per_frame(input int image_dim, input int pixels_per_beat);
        return (image_dim * image_dim) / pixels_per_beat;
    endfunction

    // A zero-bit counter is not legal, so degenerate widths collapse to one bit.
    function automatic int cnt_width(input int n);
        return (n > 0) ? n : 1;
    endfunction

endpackage

// File: rtl/lrf_valid_pipe.sv
// Enable-gated {valid,last} delay line that mirrors the fixed datapath latency.
module lrf_valid_pipe #(
    parameter int DEPTH = 10
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic v_in,
    input  logic last_in,
    output logic v_out,
    output logic last_out
);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [DEPTH-1:0] last_q;
    logic [DEPTH-1:0] last_d;

    // Shift by one stage on enabled cycles, otherwise hold every stage.
    always_comb begin
        v_d    = v_q;
        last_d = last_q;
        if (en) begin
            v_d[0]    = v_in;
            last_d[0] = last_in;
            for (int i = 1; i < DEPTH; i++) begin
                v_d[i]    = v_q[i-1];
                last_d[i] = last_q[i-1];
            end
        end else begin
            v_d    = v_q;
            last_d = last_q;
        end
    end

    // Stage registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            v_q    <= '0;
            last_q <= '0;
        end else begin
            v_q    <= v_d;
            last_q <= last_d;
        end
    end

    assign v_out    = v_q[DEPTH-1];
    assign last_out = last_q[DEPTH-1];

endmodule

// File: rtl/lrf_frame_sequencer.sv
// LRF fusion control: input handshake, beat/frame counting, warm-up FSM,
// datapath strobes and output valid tracking with back-pressure.
module lrf_frame_sequencer
    import lrf_pkg::*;
#(
    parameter  int PIXELS_PER_BEAT = 16,
    parameter  int IMAGE_DIM       = 512,
    parameter  int N_FUSE_COUNT    = 4,
    parameter  int OUT_DELAY       = 10,
    localparam int BEATS_PER_FRAME = beats_per_frame(IMAGE_DIM, PIXELS_PER_BEAT),
    localparam int N_BEATS         = $clog2(BEATS_PER_FRAME),
    localparam int FC_W            = cnt_width(N_FUSE_COUNT)
) (
    input  logic               s_axis_aclk,
    input  logic               s_axis_areset,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic               s_axis_tlast,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    output logic               dp_en,
    output logic               dp_step,
    output logic [N_BEATS-1:0] dp_beat_addr,
    output logic [1:0]         dp_avg_mode,
    output logic               dp_fuse_init,
    output logic [FC_W-1:0]    frame_cnt,
    output logic [1:0]         state,
    output logic               err_tlast
);

    localparam int FUSE_COUNT = 1 << N_FUSE_COUNT;

    lrf_state_e       state_q, state_d;
    logic [N_BEATS-1:0] beat_cnt_q, beat_cnt_d;
    logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic             err_tlast_q, err_tlast_d;
    logic             stall_s;
    logic             last_beat_s;
    logic             pipe_v_in_s;
    logic             pipe_last_in_s;
    lrf_avg_mode_e    avg_mode_s;

    assign stall_s        = m_axis_tvalid & ~m_axis_tready;
    assign dp_en          = ~stall_s;
    assign s_axis_tready  = ~stall_s & ~s_axis_areset;
    assign dp_step        = s_axis_tvalid & s_axis_tready;
    assign last_beat_s    = (beat_cnt_q == N_BEATS'(BEATS_PER_FRAME - 1));
    assign pipe_v_in_s    = dp_step & (state_q == ST_RUN);
    assign pipe_last_in_s = pipe_v_in_s & last_beat_s;

    // Counters, framing check and warm-up FSM advance only on accepted beats.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        frame_cnt_d = frame_cnt_q;
        err_tlast_d = err_tlast_q;
        if (dp_step) begin
            if (s_axis_tlast != last_beat_s) begin
                err_tlast_d = 1'b1;
            end else begin
                err_tlast_d = err_tlast_q;
            end
            if (last_beat_s) begin
                beat_cnt_d = '0;
                if (FUSE_COUNT == 1) begin
                    frame_cnt_d = '0;
                end else begin
                    frame_cnt_d = frame_cnt_q + FC_W'(1);
                end
                case (state_q)
                    ST_PRIME: state_d = (FUSE_COUNT == 1) ? ST_RUN : ST_FILL;
                    ST_FILL: begin
                        if (frame_cnt_q == FC_W'(FUSE_COUNT - 1)) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end
                    ST_RUN:   state_d = ST_RUN;
                    default:  state_d = ST_PRIME;
                endcase
            end else begin
                beat_cnt_d = beat_cnt_q + N_BEATS'(1);
            end
        end else begin
            state_d = state_q;
        end
    end

    // Average-update mode tracks the warm-up phase.
    always_comb begin
        avg_mode_s = AVG_INIT;
        case (state_q)
            ST_PRIME: avg_mode_s = AVG_INIT;
            ST_FILL:  avg_mode_s = AVG_SUB_REF;
            ST_RUN:   avg_mode_s = AVG_SUB_OLD;
            default:  avg_mode_s = AVG_INIT;
        endcase
    end

    // Control state registers; reset drops any partially received frame.
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            state_q     <= ST_PRIME;
            beat_cnt_q  <= '0;
            frame_cnt_q <= '0;
            err_tlast_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            err_tlast_q <= err_tlast_d;
        end
    end

    lrf_valid_pipe #(
        .DEPTH (OUT_DELAY)
    ) u_valid_pipe (
        .clk      (s_axis_aclk),
        .clr      (s_axis_areset),
        .en       (dp_en),
        .v_in     (pipe_v_in_s),
        .last_in  (pipe_last_in_s),
        .v_out    (m_axis_tvalid),
        .last_out (m_axis_tlast)
    );

    assign dp_beat_addr = beat_cnt_q;
    assign dp_avg_mode  = avg_mode_s;
    assign dp_fuse_init = (state_q == ST_PRIME);
    assign frame_cnt    = frame_cnt_q;
    assign state        = state_q;
    assign err_tlast    = err_tlast_q;

endmodule

// File: tb/tb_lrf_frame_sequencer.sv
// Self-checking bench: two builds (fusion window 4 and 1) share one stimulus
// stream and are compared each cycle against a beat-count based reference.
module tb_lrf_frame_sequencer;

    localparam int IMG  = 8;
    localparam int PPB  = 16;
    localparam int OD   = 3;
    localparam int BPF  = IMG * IMG / PPB;
    localparam int HMAX = 4096;

    typedef struct packed {
        logic       tv;
        logic       tl;
        logic       sready;
        logic       en;
        logic       step;
        logic [7:0] addr;
        logic [1:0] avg;
        logic       finit;
        logic [7:0] fcnt;
        logic [1:0] st;
        logic       err;
    } outs_t;

    logic clk;
    logic rst, tv, tl, tr;

    logic       a_sready, a_mtv, a_mtl, a_en, a_step, a_finit, a_err;
    logic [1:0] a_addr, a_avg, a_st, a_fcnt;
    logic       b_sready, b_mtv, b_mtl, b_en, b_step, b_finit, b_err;
    logic [1:0] b_addr, b_avg, b_st;
    logic [0:0] b_fcnt;

    int checks = 0;
    int errors = 0;

    // Reference state: beats accepted and enabled cycles since the last reset.
    int         n_acc [2];
    int         n_en  [2];
    bit         err_m [2];
    bit [1:0]   hist  [2][0:HMAX-1];
    int         fuse  [2];
    outs_t      e0, e1, o0, o1;

    lrf_frame_sequencer #(
        .PIXELS_PER_BEAT (PPB), .IMAGE_DIM (IMG), .N_FUSE_COUNT (2), .OUT_DELAY (OD)
    ) u_dut (
        .s_axis_aclk (clk), .s_axis_areset (rst), .s_axis_tvalid (tv),
        .s_axis_tready (a_sready), .s_axis_tlast (tl), .m_axis_tvalid (a_mtv),
        .m_axis_tready (tr), .m_axis_tlast (a_mtl), .dp_en (a_en), .dp_step (a_step),
        .dp_beat_addr (a_addr), .dp_avg_mode (a_avg), .dp_fuse_init (a_finit),
        .frame_cnt (a_fcnt), .state (a_st), .err_tlast (a_err)
    );

    lrf_frame_sequencer #(
        .PIXELS_PER_BEAT (PPB), .IMAGE_DIM (IMG), .N_FUSE_COUNT (0), .OUT_DELAY (OD)
    ) u_dut_nf0 (
        .s_axis_aclk (clk), .s_axis_areset (rst), .s_axis_tvalid (tv),
        .s_axis_tready (b_sready), .s_axis_tlast (tl), .m_axis_tvalid (b_mtv),
        .m_axis_tready (tr), .m_axis_tlast (b_mtl), .dp_en (b_en), .dp_step (b_step),
        .dp_beat_addr (b_addr), .dp_avg_mode (b_avg), .dp_fuse_init (b_finit),
        .frame_cnt (b_fcnt), .state (b_st), .err_tlast (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cmp(input string who, input outs_t o, input outs_t e);
        chk({who, ".m_tvalid"}, 32'(o.tv), 32'(e.tv));
        chk({who, ".m_tlast"}, 32'(o.tl), 32'(e.tl));
        chk({who, ".s_tready"}, 32'(o.sready), 32'(e.sready));
        chk({who, ".dp_en"}, 32'(o.en), 32'(e.en));
        chk({who, ".dp_step"}, 32'(o.step), 32'(e.step));
        chk({who, ".beat_addr"}, 32'(o.addr), 32'(e.addr));
        chk({who, ".avg_mode"}, 32'(o.avg), 32'(e.avg));
        chk({who, ".fuse_init"}, 32'(o.finit), 32'(e.finit));
        chk({who, ".frame_cnt"}, 32'(o.fcnt), 32'(e.fcnt));
        chk({who, ".state"}, 32'(o.st), 32'(e.st));
        chk({who, ".err_tlast"}, 32'(o.err), 32'(e.err));
    endtask

    // Expected outputs derived from beat count: frame = n/BPF, phase by frame index.
    function automatic outs_t model_out(input int d);
        outs_t    e;
        bit [1:0] h;
        int       frame;
        e = '0;
        h = (n_en[d] >= OD) ? hist[d][n_en[d] - OD] : 2'b00;
        e.tv     = h[1];
        e.tl     = h[0];
        e.en     = !(e.tv && !tr);
        e.sready = e.en && !rst;
        e.step   = tv && e.sready;
        frame    = n_acc[d] / BPF;
        e.addr   = 8'(n_acc[d] % BPF);
        e.fcnt   = 8'(frame % fuse[d]);
        e.st     = (frame == 0) ? 2'd0 : ((frame < fuse[d]) ? 2'd1 : 2'd2);
        e.avg    = e.st;
        e.finit  = (frame == 0);
        e.err    = err_m[d];
        return e;
    endfunction

    task automatic model_edge(input int d, input outs_t e);
        bit lb;
        lb = (e.addr == 8'(BPF - 1));
        if (rst) begin
            n_acc[d] = 0;
            n_en[d]  = 0;
            err_m[d] = 1'b0;
        end else begin
            if (e.en && n_en[d] < HMAX) begin
                hist[d][n_en[d]] = {e.step && e.st == 2'd2, e.step && e.st == 2'd2 && lb};
                n_en[d]++;
            end
            if (e.step) begin
                if (tl != lb) err_m[d] = 1'b1;
                n_acc[d]++;
            end
        end
    endtask

    function automatic bit lastpos0();
        return (n_acc[0] % BPF) == (BPF - 1);
    endfunction

    task automatic cycle(input bit v, input bit l, input bit r, input bit a);
        tv = v; tl = l; tr = r; rst = a;
        #1;
        e0 = model_out(0);
        e1 = model_out(1);
        o0 = {a_mtv, a_mtl, a_sready, a_en, a_step, 6'd0, a_addr, a_avg, a_finit,
              6'd0, a_fcnt, a_st, a_err};
        o1 = {b_mtv, b_mtl, b_sready, b_en, b_step, 6'd0, b_addr, b_avg, b_finit,
              7'd0, b_fcnt, b_st, b_err};
        cmp("nf2", o0, e0);
        cmp("nf0", o1, e1);
        @(posedge clk);
        model_edge(0, e0);
        model_edge(1, e1);
        #1;
    endtask

    initial begin
        fuse[0] = 4;
        fuse[1] = 1;
        for (int d = 0; d < 2; d++) begin
            n_acc[d] = 0; n_en[d] = 0; err_m[d] = 1'b0;
        end
        rst = 1'b1; tv = 1'b0; tl = 1'b0; tr = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);

        // Continuous input over five frames: warm-up then first output frame.
        for (int i = 0; i < 20; i++) cycle(1'b1, lastpos0(), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // Output back-pressure mid-frame while in RUN.
        for (int i = 0; i < 6; i++) cycle(1'b1, lastpos0(), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, lastpos0(), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, lastpos0(), 1'b1, 1'b0);

        // Gapped input, one beat every other cycle.
        for (int i = 0; i < 8; i++) cycle(i % 2 == 0, lastpos0(), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // Random valid/ready traffic with well-formed framing.
        for (int i = 0; i < 120; i++)
            cycle($urandom_range(0, 3) != 0, lastpos0(), $urandom_range(0, 3) != 0, 1'b0);

        // Early tlast on beat 1 of frame 2 after a fresh reset.
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 14; i++) cycle(1'b1, lastpos0() || (n_acc[0] == 9), 1'b1, 1'b0);

        // Reset at beat 2 of frame 5 while output is valid.
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 22; i++) cycle(1'b1, lastpos0(), 1'b1, 1'b0);
        cycle(1'b1, lastpos0(), 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b1, lastpos0(), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lrf_frame_sequencer.md
Name: lrf_frame_sequencer

Overview:
- Control block for the LRF fusion datapath. It accepts the input AXI-Stream handshake, counts beats and frames, and walks the warm-up sequence: prime, then fill the 2^N_FUSE_COUNT window, then run.
- It drives per-beat mode and enable strobes for the average/fused-frame LSUs and the HSSIM/fusion pipeline.
- It tracks output-beat validity through the fixed-latency datapath with a delay line, generates m_axis_tvalid/tlast from it, and back-pressures the input.

Parameters:
PIXELS_PER_BEAT, 16, pixels per stream beat
IMAGE_DIM, 512, frame width and height in pixels
N_FUSE_COUNT, 4, log2 of fusion window (FUSE_COUNT = 2^N_FUSE_COUNT)
OUT_DELAY, 10, datapath latency in enabled cycles (>=1)
Derived: BEATS_PER_FRAME = IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT; N_BEATS = $clog2(BEATS_PER_FRAME)

Ports:
s_axis_aclk  in  1  clock
s_axis_areset  in  1  reset; synchronous, active-high
s_axis_tvalid  in  1  input beat valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  input end-of-frame marker
m_axis_tvalid  out  1  output beat valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  output end-of-frame
dp_en  out  1  datapath pipeline advance enable
dp_step  out  1  input beat accepted this cycle
dp_beat_addr  out  N_BEATS  LSU address of the accepted beat
dp_avg_mode  out  2  0=INIT (avg=FUSE_COUNT*f), 1=SUB_REF (avg+=f-f0), 2=SUB_OLD (avg+=f-f(n-FUSE_COUNT))
dp_fuse_init  out  1  write fused = new beat (first frame)
frame_cnt  out  max(N_FUSE_COUNT,1)  frame index modulo FUSE_COUNT
state  out  2  PRIME=0, FILL=1, RUN=2
err_tlast  out  1  sticky framing error

Behaviour:
- Combinational control:
  - stall = m_axis_tvalid & ~m_axis_tready
  - dp_en = ~stall
  - s_axis_tready = ~stall (0 while s_axis_areset is high)
  - dp_step = s_axis_tvalid & s_axis_tready
  - dp_beat_addr = beat_cnt
  - dp_fuse_init = (state==PRIME)
  - dp_avg_mode: PRIME->0, FILL->1, RUN->2
- Reset (sync, high): state=PRIME, beat_cnt=0, frame_cnt=0, delay line cleared, m_axis_tvalid=0, m_axis_tlast=0, err_tlast=0. Takes effect on the next edge regardless of the current frame position. A partial frame is discarded.
- beat_cnt: increments on dp_step. last_beat = (beat_cnt==BEATS_PER_FRAME-1). On dp_step & last_beat it wraps to 0.
- frame_cnt: increments modulo FUSE_COUNT on dp_step & last_beat.
- Framing is internal:
  - dp_step with s_axis_tlast != last_beat sets err_tlast (sticky until reset).
  - The counters ignore s_axis_tlast.
- FSM transitions, evaluated on dp_step & last_beat:
  - PRIME -> FILL; if FUSE_COUNT==1, PRIME -> RUN.
  - FILL -> RUN when frame_cnt==FUSE_COUNT-1; otherwise stay in FILL.
  - RUN stays in RUN.
- Delay line: OUT_DELAY stages of {v,last}; shifts only when dp_en.
  - Stage 0 input: v = dp_step & (state==RUN); last = dp_step & (state==RUN) & last_beat.
  - Cycles with no accepted beat insert a bubble.
  - m_axis_tvalid/tlast = final stage.
- Latency: a RUN beat accepted at edge t appears on m_axis at t+OUT_DELAY with no stall. Each stall cycle adds one.
- PRIME/FILL beats advance the datapath but never produce m_axis_tvalid.
- Stall freezes the delay line, the counters (no dp_step) and the datapath, simultaneously.
- m_axis_tvalid held with tready low: tvalid and tlast stay stable until accepted.
- Simultaneous output accept and input accept: allowed in the same cycle. There is no bubble penalty, so full throughput is 1 beat/cycle.

Decomposition:
- Package lrf_pkg: state encodings, avg-mode encodings, beats_per_frame/width functions.
- One sub-module lrf_valid_pipe: enable-gated {v,last} shift register, depth OUT_DELAY, sync clear.

Test Plan:
Params for all scenarios: IMAGE_DIM=8, PIXELS_PER_BEAT=16 (4 beats/frame), N_FUSE_COUNT=2, OUT_DELAY=3.
1. Continuous tvalid, tready=1, 5 frames:
   - frames 0-3 give no m_axis_tvalid.
   - state PRIME(4 beats) -> FILL(12 beats) -> RUN; dp_avg_mode 0,1,1,1,2.
   - The first m_axis_tvalid occurs 3 cycles after the first frame-4 beat; m_axis_tlast lands on the 4th beat of the frame.
2. RUN, m_axis_tready low for 5 cycles mid-frame:
   - s_axis_tready=0 and dp_en=0 during the stall.
   - m_axis_tvalid/tlast are held; beat_cnt is frozen.
   - After release, there are 4 output beats per frame with no loss or duplication.
3. Gapped input (tvalid 1-0-1-0) in RUN:
   - Output beats are spaced identically, each 3 cycles after its input.
   - dp_beat_addr is 0,1,2,3.
4. s_axis_tlast asserted on beat 1 of frame 2 -> err_tlast=1 from the next cycle and stays 1; frame_cnt still advances only after beat 3.
5. Reset pulse at beat 2 of frame 5 while m_axis_tvalid=1:
   - the next cycle shows m_axis_tvalid=0, state=PRIME, beat_cnt=0, frame_cnt=0.
   - the following frame gets dp_fuse_init=1.
6. N_FUSE_COUNT=0 build: the frame after PRIME is RUN with dp_avg_mode=2, and output begins with the second frame.
